// File: rtl/pipe_pkg.sv
// Shared types for the MIPS pipeline control slice: forwarding selects,
// exception sequencer states and the canonical bubble instruction.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ENTER  = 2'b01,
    KERNEL = 2'b10
  } exc_state_t;

  // sll r0, r0, 0 -- what a flushed pipeline register carries
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/mdu_busy_ctr.sv
// Busy countdown for the multi-cycle multiply/divide unit: a start loads
// MDU_LAT, the count then falls to zero and busy is high while nonzero.
module mdu_busy_ctr #(
  parameter int MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  output logic       busy,
  output logic [3:0] count
);

  localparam logic [3:0] LAT = 4'(MDU_LAT);

  logic [3:0] cnt;

  // A start while already busy simply reloads the full latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LAT;
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign busy  = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Stall/forward/flush controller for the 5-stage pipeline, with MDU busy
// tracking and a precise-exception entry / eret return sequencer.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int               REG_AW     = 5,
  parameter int               XLEN       = 32,
  parameter int               MDU_LAT    = 4,
  parameter logic [XLEN-1:0]  EXC_VECTOR = 32'h8000_0180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic              uses_rs_d,
  input  logic              uses_rt_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              branch_d,
  input  logic              jump_reg_d,
  input  logic              mdu_d,
  input  logic              eret_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              regwrite_e,
  input  logic              load_e,
  input  logic              mdu_start_e,
  input  logic [REG_AW-1:0] writereg_m,
  input  logic              regwrite_m,
  input  logic              load_m,
  input  logic [REG_AW-1:0] writereg_w,
  input  logic              regwrite_w,
  input  logic              exc_req,
  input  logic [XLEN-1:0]   exc_pc,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              pc_redirect,
  output logic [XLEN-1:0]   pc_target,
  output logic              mdu_busy,
  output logic              kernel_mode,
  output logic [XLEN-1:0]   epc
);

  exc_state_t       state, nextState;
  logic [XLEN-1:0]  epcReg;
  logic             mduBusy;
  logic [3:0]       mduCnt;
  logic             mduStart;
  logic             srcHitE, srcHitM;
  logic             loadUse, branchHaz, mduHaz, hazStall, eretFire;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic regMatch(input logic [REG_AW-1:0] src,
                                    input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic fwd_sel_t eSel(input logic [REG_AW-1:0] src);
    if (regwrite_m && !load_m && regMatch(src, writereg_m)) return FWD_M;
    else if (regwrite_w && regMatch(src, writereg_w))       return FWD_W;
    else                                                    return FWD_RF;
  endfunction

  assign srcHitE = (uses_rs_d & regMatch(rs_d, writereg_e)) |
                   (uses_rt_d & regMatch(rt_d, writereg_e));
  assign srcHitM = (uses_rs_d & regMatch(rs_d, writereg_m)) |
                   (uses_rt_d & regMatch(rt_d, writereg_m));

  assign loadUse   = load_e & regwrite_e & srcHitE;
  assign branchHaz = (branch_d | jump_reg_d) &
                     ((regwrite_e & srcHitE) | (load_m & srcHitM));
  assign mduHaz    = mdu_d & (mduCnt != '0);
  assign hazStall  = loadUse | branchHaz | mduHaz;
  // eret only leaves kernel once nothing ahead of it is holding D.
  assign eretFire  = (state == KERNEL) & eret_d & valid_d & ~hazStall;

  // No synchronous abort path exists for the MDU; flushed starts never load.
  assign mduStart = mdu_start_e & ~flush_e;

  mdu_busy_ctr #(.MDU_LAT(MDU_LAT)) uMduCtr (
    .clk   (clk),
    .reset (reset),
    .start (mduStart),
    .clear (1'b0),
    .busy  (mduBusy),
    .count (mduCnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      epcReg <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && exc_req) epcReg <= exc_pc;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (exc_req) nextState = ENTER;
      ENTER:   nextState = KERNEL;
      KERNEL:  if (eretFire) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Everything is held at zero while reset is asserted, even the
  // purely input-driven forwarding selects.
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    fwd_a_d     = 1'b0;
    fwd_b_d     = 1'b0;
    fwd_a_e     = FWD_RF;
    fwd_b_e     = FWD_RF;
    pc_redirect = 1'b0;
    pc_target   = '0;
    mdu_busy    = 1'b0;
    kernel_mode = 1'b0;
    if (reset) begin
      fwd_a_e     = eSel(rs_e);
      fwd_b_e     = eSel(rt_e);
      fwd_a_d     = regwrite_m & ~load_m & regMatch(rs_d, writereg_m);
      fwd_b_d     = regwrite_m & ~load_m & regMatch(rt_d, writereg_m);
      mdu_busy    = mduBusy;
      kernel_mode = (state == KERNEL);
      if (state == ENTER) begin
        flush_d     = 1'b1;
        flush_e     = 1'b1;
        flush_m     = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = EXC_VECTOR;
      end else begin
        stall_f = hazStall;
        stall_d = hazStall;
        flush_e = hazStall;
        if (eretFire) begin
          pc_redirect = 1'b1;
          pc_target   = epcReg;
          flush_d     = 1'b1;
        end
      end
    end
  end

  assign epc = epcReg;

endmodule
